cpc_audio_mixer: RTL and testbench
==================================

# cpc_audio_mixer

Parametrised, time-multiplexed stereo mixer for N unsigned sound channels (one AY/YM2149 gives 3, PlayCity-style expansions give 6 or more). Replaces the fixed combinational left/right sum on the motherboard, which hard-wires A→left, C→right, B→both. Each channel gets an independent 2-bit gain per side. A master attenuation shift is applied after accumulation, and the result is saturated to the output width. The block sits between the PSG channel outputs and the core's audio_l/audio_r outputs.

## Interface
- NCH, 6: number of input channels (≥1)
- IW, 8: channel sample width (unsigned)
- OW, 8: output sample width (unsigned)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- ce  in  1  sample strobe; requests one mix
- ch  in  NCH*IW  packed samples; channel i = ch[i*IW +: IW]
- gain_l  in  NCH*2  per-channel left gain code; channel i = gain_l[2i +: 2]
- gain_r  in  NCH*2  per-channel right gain code, same packing
- mshift  in  2  master right-shift (0..3) applied to both sums
- flag_clr  in  1  clears the sticky flags
- audio_l  out  OW  mixed left sample (registered)
- audio_r  out  OW  mixed right sample (registered)
- valid  out  1  one-clock pulse when audio_l/audio_r update
- busy  out  1  mix in progress
- clip_l, clip_r  out  1 each  sticky saturation flags
- ovr  out  1  sticky flag: ce dropped while busy

## Operation
- Gain codes: 0 = mute, 1 = sample>>3, 2 = sample>>2, 3 = sample>>1. Shifts truncate.
- Accumulator width: AW = IW + clog2(NCH), one per side. Each term is ≤ (2^IW-1)>>1, so the accumulator never wraps.
- States:
  - IDLE
  - ACC: index i = 0..NCH-1, one channel per clk
  - OUT
- IDLE with ce=1:
  - snapshot ch, gain_l, gain_r and mshift into internal registers
  - clear both accumulators, set i=0, go to ACC
- ACC:
  - acc_l += scale(ch_i, gain_l_i); acc_r += scale(ch_i, gain_r_i)
  - at i=NCH-1 go to OUT, otherwise i++
- OUT:
  - per side: v = acc >> mshift
  - if v > 2^OW-1, output 2^OW-1 and set the clip flag for that side; otherwise output v[OW-1:0]
  - pulse valid; return to IDLE
- Only the snapshot is used. Input changes after ce is accepted do not affect the current mix.
- ce in ACC or OUT is ignored and sets ovr.
- flag_clr clears clip_l, clip_r and ovr. If a set and flag_clr occur in the same cycle, the set wins.
- Legacy equivalence with NCH=3, OW=8, mshift=0:
  - gain_l = {C:0, B:2, A:3}
  - gain_r = {C:3, B:2, A:0}
  - this reproduces audio_l = A>>1 + B>>2 and audio_r = C>>1 + B>>2

## Timing
- ce sampled high in IDLE at edge t:
  - ACC occupies edges t+1 .. t+NCH
  - OUT at edge t+NCH+1 registers audio_l/audio_r and valid=1
  - latency is NCH+1 clocks
- busy = 1 in ACC and OUT (NCH+1 clocks). The next ce is accepted at the first edge after valid.
- Maximum mix rate is one per NCH+2 clocks. The 1 MHz PSG strobe is far below this.
- valid is high for exactly one clock. audio_l/audio_r hold their values until the next OUT.
- Reset (asynchronous):
  - state IDLE, i=0, accumulators 0
  - audio_l = audio_r = 0; valid, busy, clip_l, clip_r, ovr = 0
- Reset mid-mix: aborts with no valid pulse. Outputs stay 0. The first ce after reset deassertion starts a clean mix.

## Test plan
- Legacy map (NCH=3, OW=8), A=0xFF, B=0xFF, C=0x00, ce once -> audio_l=190, audio_r=63, valid exactly 4 clocks after ce, busy high for 4 clocks.
- Saturation (NCH=6), all channels 0xFF, all gains 3, mshift=0 -> sum 762 -> audio_l=audio_r=255, clip_l=clip_r=1; flag_clr pulse -> both flags 0.
- Mute and master shift: legacy map with mshift=2 -> audio_l=47, audio_r=15. All gains 0 -> outputs 0, no clip.
- Snapshot/overrun: ce, then change ch to 0x00 and pulse ce again on the next clock -> result uses the original samples, second ce ignored, ovr=1, exactly one valid pulse.
- Flag priority: a clipping mix whose OUT cycle coincides with flag_clr -> clip_l remains 1.
- Reset asserted asynchronously mid-ACC -> outputs immediately 0, no valid pulse. After release, a ce gives the correct result NCH+1 clocks later.

Source files
------------

// File: rtl/cpc_audio_mixer.sv
// Time-multiplexed stereo mixer: N unsigned channels, 2-bit gain per side,
// master attenuation shift and output saturation with sticky flags.
module cpc_audio_mixer #(
  parameter int NCH = 6,
  parameter int IW  = 8,
  parameter int OW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [NCH*IW-1:0] ch,
  input  logic [NCH*2-1:0]  gain_l,
  input  logic [NCH*2-1:0]  gain_r,
  input  logic [1:0]        mshift,
  input  logic              flag_clr,
  output logic [OW-1:0]     audio_l,
  output logic [OW-1:0]     audio_r,
  output logic              valid,
  output logic              busy,
  output logic              clip_l,
  output logic              clip_r,
  output logic              ovr
);

  localparam int AW  = IW + $clog2(NCH);
  localparam int IXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int XW  = AW + OW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]        r_state;
  logic [IXW-1:0]    r_idx;
  logic [AW-1:0]     r_acc_l, r_acc_r;
  logic [NCH*IW-1:0] r_ch;
  logic [NCH*2-1:0]  r_gl, r_gr;
  logic [1:0]        r_mshift;
  logic [OW-1:0]     r_audio_l, r_audio_r;
  logic              r_valid, r_clip_l, r_clip_r, r_ovr;

  logic [IW-1:0]     w_smp, w_term_l, w_term_r;
  logic [AW-1:0]     w_vl, w_vr;
  logic [XW-1:0]     w_vl_x, w_vr_x, w_max_x;
  logic              w_sat_l, w_sat_r, w_out;

  function automatic logic [IW-1:0] f_scale(input logic [IW-1:0] s, input logic [1:0] g);
    case (g)
      2'd1:    f_scale = s >> 3;
      2'd2:    f_scale = s >> 2;
      2'd3:    f_scale = s >> 1;
      default: f_scale = '0;
    endcase
  endfunction

  assign w_smp    = r_ch[r_idx*IW +: IW];
  assign w_term_l = f_scale(w_smp, r_gl[r_idx*2 +: 2]);
  assign w_term_r = f_scale(w_smp, r_gr[r_idx*2 +: 2]);

  // Widen before the saturation compare so OW > AW configurations stay correct.
  assign w_vl    = r_acc_l >> r_mshift;
  assign w_vr    = r_acc_r >> r_mshift;
  assign w_vl_x  = {{OW{1'b0}}, w_vl};
  assign w_vr_x  = {{OW{1'b0}}, w_vr};
  assign w_max_x = {{AW{1'b0}}, {OW{1'b1}}};
  assign w_sat_l = (w_vl_x > w_max_x);
  assign w_sat_r = (w_vr_x > w_max_x);
  assign w_out   = (r_state == S_OUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      r_ch      <= '0;
      r_gl      <= '0;
      r_gr      <= '0;
      r_mshift  <= '0;
      r_audio_l <= '0;
      r_audio_r <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (ce) begin
          r_ch     <= ch;
          r_gl     <= gain_l;
          r_gr     <= gain_r;
          r_mshift <= mshift;
          r_acc_l  <= '0;
          r_acc_r  <= '0;
          r_idx    <= '0;
          r_state  <= S_ACC;
        end
        S_ACC: begin
          r_acc_l <= r_acc_l + AW'(w_term_l);
          r_acc_r <= r_acc_r + AW'(w_term_r);
          if (r_idx == IXW'(NCH - 1)) r_state <= S_OUT;
          else                        r_idx   <= r_idx + 1'b1;
        end
        S_OUT: begin
          r_audio_l <= w_sat_l ? {OW{1'b1}} : w_vl_x[OW-1:0];
          r_audio_r <= w_sat_r ? {OW{1'b1}} : w_vr_x[OW-1:0];
          r_valid   <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as flag_clr takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clip_l <= 1'b0;
      r_clip_r <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_out && w_sat_l)  r_clip_l <= 1'b1;
      else if (flag_clr)     r_clip_l <= 1'b0;
      if (w_out && w_sat_r)  r_clip_r <= 1'b1;
      else if (flag_clr)     r_clip_r <= 1'b0;
      if (ce && r_state != S_IDLE) r_ovr <= 1'b1;
      else if (flag_clr)           r_ovr <= 1'b0;
    end
  end

  assign audio_l = r_audio_l;
  assign audio_r = r_audio_r;
  assign valid   = r_valid;
  assign busy    = (r_state != S_IDLE);
  assign clip_l  = r_clip_l;
  assign clip_r  = r_clip_r;
  assign ovr     = r_ovr;

endmodule

// File: tb/tb_cpc_audio_mixer.sv
// Directed bench: a 3-channel instance for the legacy map and a 6-channel
// instance for saturation, flag priority and asynchronous reset.
module tb_cpc_audio_mixer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: NCH=3
  logic        a_ce, a_clr;
  logic [23:0] a_ch;
  logic [5:0]  a_gl, a_gr;
  logic [1:0]  a_ms;
  logic [7:0]  a_l, a_r;
  logic        a_valid, a_busy, a_cl, a_cr, a_ovr;

  // Instance B: NCH=6
  logic        b_ce, b_clr;
  logic [47:0] b_ch;
  logic [11:0] b_gl, b_gr;
  logic [1:0]  b_ms;
  logic [7:0]  b_l, b_r;
  logic        b_valid, b_busy, b_cl, b_cr, b_ovr;

  cpc_audio_mixer #(.NCH(3), .IW(8), .OW(8)) u_a (
    .clk(clk), .reset(reset), .ce(a_ce), .ch(a_ch), .gain_l(a_gl), .gain_r(a_gr),
    .mshift(a_ms), .flag_clr(a_clr), .audio_l(a_l), .audio_r(a_r), .valid(a_valid),
    .busy(a_busy), .clip_l(a_cl), .clip_r(a_cr), .ovr(a_ovr));

  cpc_audio_mixer #(.NCH(6), .IW(8), .OW(8)) u_b (
    .clk(clk), .reset(reset), .ce(b_ce), .ch(b_ch), .gain_l(b_gl), .gain_r(b_gr),
    .mshift(b_ms), .flag_clr(b_clr), .audio_l(b_l), .audio_r(b_r), .valid(b_valid),
    .busy(b_busy), .clip_l(b_cl), .clip_r(b_cr), .ovr(b_ovr));

  int n_vec = 0;
  int n_err = 0;
  int pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Legacy map: ch = {C,B,A}, gain_l = {C:0,B:2,A:3}, gain_r = {C:3,B:2,A:0}
  localparam logic [23:0] LEG_CH = 24'h00FFFF;
  localparam logic [5:0]  LEG_GL = 6'b00_10_11;
  localparam logic [5:0]  LEG_GR = 6'b11_10_00;

  initial begin
    reset = 1'b1;
    a_ce = 0; a_clr = 0; a_ch = '0; a_gl = '0; a_gr = '0; a_ms = '0;
    b_ce = 0; b_clr = 0; b_ch = '0; b_gl = '0; b_gr = '0; b_ms = '0;
    tick(); tick();
    chk("rst_audio_l", a_l, 0);
    chk("rst_audio_r", a_r, 0);
    chk("rst_flags", {a_valid, a_busy, a_cl, a_cr, a_ovr}, 0);
    reset = 1'b0;
    tick();

    // Legacy mix with cycle-accurate latency and busy window
    a_ch = LEG_CH; a_gl = LEG_GL; a_gr = LEG_GR; a_ms = 2'd0; a_ce = 1;
    tick(); a_ce = 0;
    chk("leg_busy_t0", {a_busy, a_valid}, 2'b10);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("leg_busy_acc", {a_busy, a_valid}, 2'b10);
    end
    tick();
    chk("leg_valid_t4", {a_busy, a_valid}, 2'b01);
    chk("leg_audio_l", a_l, 190);
    chk("leg_audio_r", a_r, 63);
    tick();
    chk("leg_valid_drop", a_valid, 0);
    chk("leg_hold_l", a_l, 190);

    // Master shift 2
    a_ms = 2'd2; a_ce = 1;
    tick(); a_ce = 0;
    pulses = 0;
    for (int k = 0; k < 10 && pulses == 0; k++) begin
      tick();
      if (a_valid) pulses++;
    end
    chk("msh_seen", pulses, 1);
    chk("msh_audio_l", a_l, 47);
    chk("msh_audio_r", a_r, 15);

    // All muted
    a_ms = 2'd0; a_gl = '0; a_gr = '0; a_ce = 1;
    tick(); a_ce = 0;
    repeat (4) tick();
    chk("mute_valid", a_valid, 1);
    chk("mute_out", {a_l, a_r}, 0);
    chk("mute_clip", {a_cl, a_cr}, 0);

    // Snapshot and overrun
    chk("ovr_before", a_ovr, 0);
    a_ch = LEG_CH; a_gl = LEG_GL; a_gr = LEG_GR; a_ce = 1;
    tick();
    a_ch = '0;
    tick(); a_ce = 0;
    chk("ovr_set", a_ovr, 1);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (a_valid) pulses++;
      tick();
    end
    chk("snap_pulses", pulses, 1);
    chk("snap_audio_l", a_l, 190);
    chk("snap_audio_r", a_r, 63);
    a_clr = 1; tick(); a_clr = 0;
    chk("ovr_clr", a_ovr, 0);

    // Saturation on NCH=6: 6 * 127 = 762
    b_ch = {6{8'hFF}}; b_gl = {6{2'd3}}; b_gr = {6{2'd3}}; b_ms = 2'd0; b_ce = 1;
    tick(); b_ce = 0;
    repeat (6) tick();
    chk("sat_busy_last", {b_busy, b_valid}, 2'b10);
    tick();
    chk("sat_valid", b_valid, 1);
    chk("sat_audio", {b_l, b_r}, 16'hFFFF);
    chk("sat_clip", {b_cl, b_cr}, 2'b11);
    b_clr = 1; tick(); b_clr = 0;
    chk("sat_clr", {b_cl, b_cr}, 2'b00);

    // flag_clr coincident with the clipping OUT cycle
    b_ce = 1;
    tick(); b_ce = 0;
    repeat (6) tick();
    b_clr = 1;
    tick(); b_clr = 0;
    chk("prio_valid", b_valid, 1);
    chk("prio_clip", {b_cl, b_cr}, 2'b11);
    b_clr = 1; tick(); b_clr = 0;
    chk("prio_clr_after", {b_cl, b_cr}, 2'b00);

    // Async reset mid-ACC: left 6*32=192, right 6*8=48
    b_ch = {6{8'h40}}; b_gl = {6{2'd3}}; b_gr = {6{2'd1}}; b_ce = 1;
    tick(); b_ce = 0;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_audio", {b_l, b_r}, 0);
    chk("arst_busy", {b_busy, b_valid}, 0);
    pulses = 0;
    repeat (2) begin
      tick();
      if (b_valid) pulses++;
    end
    #2 reset = 1'b0;
    repeat (8) begin
      tick();
      if (b_valid) pulses++;
    end
    chk("arst_no_valid", pulses, 0);
    chk("arst_hold0", {b_l, b_r}, 0);
    b_ce = 1;
    tick(); b_ce = 0;
    repeat (6) tick();
    chk("post_busy", {b_busy, b_valid}, 2'b10);
    tick();
    chk("post_valid", b_valid, 1);
    chk("post_audio_l", b_l, 192);
    chk("post_audio_r", b_r, 48);
    chk("post_clip", {b_cl, b_cr}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
